// File: rtl/hero_key_conditioner.sv
// Direction push-button conditioner: per-button sync + debounce, then press-edge
// arbitration and hold-to-repeat into one-hot, single-cycle move pulses.
module hero_key_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY    = 16,
  parameter int unsigned REPEAT_PERIOD   = 8,
  parameter bit          REPEAT_EN       = 1'b1
) (
  input  logic       clk_1,
  input  logic       rst,
  input  logic       en,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic       up,
  output logic       down,
  output logic       left,
  output logic       right,
  output logic [3:0] key_state
);

  localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned RC_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RC_W   = $clog2(RC_MAX) + 1;

  localparam logic [DB_W-1:0] DB_LAST     = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [RC_W-1:0] DELAY_LAST  = RC_W'(REPEAT_DELAY - 1);
  localparam logic [RC_W-1:0] PERIOD_LAST = RC_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2
  } state_t;

  // Bit order everywhere: [3]=up, [2]=down, [1]=left, [0]=right
  logic [3:0]      raw_c;
  logic [3:0]      sync1;
  logic [3:0]      sync2;
  logic [3:0]      key_d;
  logic [DB_W-1:0] cnt [4];

  state_t          state, state_nx;
  logic [1:0]      dir, dir_nx;
  logic [RC_W-1:0] rc, rc_nx;
  logic [3:0]      pulse, pulse_nx;
  logic [3:0]      rise_c;
  logic [1:0]      win_c;

  assign raw_c = {btn_up, btn_down, btn_left, btn_right};

  // Two-flop synchroniser for the asynchronous buttons
  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_c;
      sync2 <= sync1;
    end
  end

  // Stable-count debouncer; counter is cleared on acceptance so it never exceeds DB_LAST
  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      key_state <= '0;
      key_d     <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      key_d <= key_state;
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == key_state[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          key_state[i] <= sync2[i];
          cnt[i]       <= '0;
        end else begin
          cnt[i] <= cnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign rise_c = key_state & ~key_d;

  // Fixed priority among simultaneous press edges
  always_comb begin
    win_c = 2'd0;
    if (rise_c[3])      win_c = 2'd3;
    else if (rise_c[2]) win_c = 2'd2;
    else if (rise_c[1]) win_c = 2'd1;
  end

  always_ff @(posedge clk_1 or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      dir   <= 2'd0;
      rc    <= '0;
      pulse <= '0;
    end else begin
      state <= state_nx;
      dir   <= dir_nx;
      rc    <= rc_nx;
      pulse <= pulse_nx;
    end
  end

  // Repeat FSM; a fresh press edge preempts any hold/repeat in progress
  always_comb begin
    state_nx = state;
    dir_nx   = dir;
    rc_nx    = rc;
    pulse_nx = '0;
    if (!en) begin
      state_nx = IDLE;
      rc_nx    = '0;
    end else if (rise_c != 4'b0000) begin
      pulse_nx[win_c] = 1'b1;
      dir_nx          = win_c;
      rc_nx           = '0;
      state_nx        = HOLD;
    end else begin
      case (state)
        IDLE: begin
          rc_nx = '0;
        end
        HOLD: begin
          if (!key_state[dir]) begin
            state_nx = IDLE;
            rc_nx    = '0;
          end else if (rc == DELAY_LAST) begin
            if (REPEAT_EN) begin
              pulse_nx[dir] = 1'b1;
              rc_nx         = '0;
              state_nx      = REPEAT;
            end
          end else begin
            rc_nx = rc + RC_W'(1);
          end
        end
        REPEAT: begin
          if (!key_state[dir]) begin
            state_nx = IDLE;
            rc_nx    = '0;
          end else if (rc == PERIOD_LAST) begin
            pulse_nx[dir] = 1'b1;
            rc_nx         = '0;
          end else begin
            rc_nx = rc + RC_W'(1);
          end
        end
        default: begin
          state_nx = IDLE;
          rc_nx    = '0;
        end
      endcase
    end
  end

  assign up    = pulse[3];
  assign down  = pulse[2];
  assign left  = pulse[1];
  assign right = pulse[0];

endmodule

// File: tb/tb_hero_key_conditioner.sv
// Scoreboard bench for hero_key_conditioner: directed button scenarios push the
// expected pulse cycle/direction; a negedge monitor pops and compares every pulse.
module tb_hero_key_conditioner;

  logic       clk_1 = 1'b0;
  logic       rst   = 1'b0;
  logic       en    = 1'b1;
  logic [3:0] btns  = 4'b0000;  // {up,down,left,right}
  logic       up, down, left, right;
  logic [3:0] key_state;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    int         cyc;
    logic [3:0] vec;
  } exp_t;

  exp_t sb[$];

  hero_key_conditioner dut (
    .clk_1     (clk_1),
    .rst       (rst),
    .en        (en),
    .btn_up    (btns[3]),
    .btn_down  (btns[2]),
    .btn_left  (btns[1]),
    .btn_right (btns[0]),
    .up        (up),
    .down      (down),
    .left      (left),
    .right     (right),
    .key_state (key_state)
  );

  always #5 clk_1 = ~clk_1;

  always @(posedge clk_1) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %b expected %b", name, cyc, act, exp_v);
    end
  endtask

  task automatic expect_pulse(input int c, input logic [3:0] v);
    exp_t e;
    e.cyc = c;
    e.vec = v;
    sb.push_back(e);
  endtask

  // Monitor: every observed pulse must match the head of the scoreboard
  always @(negedge clk_1) begin
    logic [3:0] p;
    exp_t       e;
    p = {up, down, left, right};
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      n_vec++;
      n_bad++;
      $display("FAIL missed_pulse: got none at cyc %0d expected %b", e.cyc, e.vec);
    end
    if (p !== 4'b0000) begin
      n_vec++;
      if (sb.size() == 0 || sb[0].cyc != cyc) begin
        n_bad++;
        $display("FAIL unexpected_pulse @cyc %0d: got %b expected 0000", cyc, p);
      end else begin
        e = sb.pop_front();
        if (p !== e.vec) begin
          n_bad++;
          $display("FAIL pulse_dir @cyc %0d: got %b expected %b", cyc, p, e.vec);
        end
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk_1);
  endtask

  initial begin
    int t;
    int r;

    // 1: asynchronous reset with buttons low
    #2 rst = 1'b1;
    #1 chk("rst_async", {up, down, left, right, key_state}, 8'h00);
    cycles(3);
    chk("rst_held", {up, down, left, right, key_state}, 8'h00);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_1);
      if (i % 5 == 4) chk("post_rst_idle", {up, down, left, right, key_state}, 8'h00);
    end

    // 2: bouncing right button never accepted
    for (int i = 0; i < 12; i++) begin
      btns[0] = ~btns[0];
      @(negedge clk_1);
    end
    btns = 4'b0000;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_1);
      if (i % 4 == 0) chk("bounce_key_state", {4'h0, key_state}, 8'h00);
    end

    // 3: short up press -> single pulse at T+7
    t = cyc + 1;
    btns = 4'b1000;
    expect_pulse(t + 7, 4'b1000);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_1);
      if (cyc == t + 5) chk("up_key_pre", {4'h0, key_state}, 8'h00);
      if (cyc == t + 6) chk("up_key_set", {4'h0, key_state}, 8'h08);
      if (cyc == t + 9) btns = 4'b0000;
    end
    chk("up_released", {4'h0, key_state}, 8'h00);

    // 4: held left -> first pulse, delayed repeat, periodic repeats
    t = cyc + 1;
    btns = 4'b0010;
    expect_pulse(t + 7,  4'b0010);
    expect_pulse(t + 23, 4'b0010);
    expect_pulse(t + 31, 4'b0010);
    expect_pulse(t + 39, 4'b0010);
    expect_pulse(t + 47, 4'b0010);
    expect_pulse(t + 55, 4'b0010);
    for (int i = 0; i < 49; i++) @(negedge clk_1);
    chk("left_held_key", {4'h0, key_state}, 8'h02);
    btns = 4'b0000;
    cycles(40);

    // 5: up and right together -> up wins, right never pulses
    t = cyc + 1;
    btns = 4'b1001;
    expect_pulse(t + 7, 4'b1000);
    for (int i = 0; i < 12; i++) @(negedge clk_1);
    chk("both_held_key", {4'h0, key_state}, 8'h09);
    btns = 4'b0001;
    cycles(40);
    chk("right_only_key", {4'h0, key_state}, 8'h01);
    btns = 4'b0000;
    cycles(20);

    // 6: down held, reset mid-repeat, then an enable window
    t = cyc + 1;
    btns = 4'b0100;
    expect_pulse(t + 7,  4'b0100);
    expect_pulse(t + 23, 4'b0100);
    while (cyc < t + 26) @(negedge clk_1);
    #2 rst = 1'b1;
    #1 chk("rst_mid_async", {up, down, left, right, key_state}, 8'h00);
    cycles(2);
    chk("rst_mid_held", {up, down, left, right, key_state}, 8'h00);
    rst = 1'b0;
    r = cyc + 1;
    expect_pulse(r + 7, 4'b0100);
    while (cyc < r + 10) @(negedge clk_1);
    en = 1'b0;
    cycles(20);
    chk("en_off_key", {4'h0, key_state}, 8'h04);
    en = 1'b1;
    cycles(30);
    btns = 4'b0000;
    cycles(20);

    chk("sb_drained", 8'(sb.size()), 8'h00);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
